// File: rtl/riscv_pkg.sv
// Shared RV32I decode types: word/ALU/operand-select types, opcode and funct constants,
// the decoded-instruction payload and the output-buffer state encoding.
package riscv_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned ALU_OPW = 4;

    typedef logic [XLEN-1:0]   word_t;
    typedef logic [REG_AW-1:0] reg_idx_t;

    typedef enum logic [ALU_OPW-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_OP2  = 4'd10
    } alu_op_t;

    typedef enum logic [1:0] {
        OP1_RS1  = 2'd0,
        OP1_PC   = 2'd1,
        OP1_ZERO = 2'd2
    } op1_sel_t;

    typedef enum logic [1:0] {
        OP2_RS2  = 2'd0,
        OP2_IMM  = 2'd1,
        OP2_FOUR = 2'd2
    } op2_sel_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } skid_state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        alu_op_t  alu_op;
        op1_sel_t op1_sel;
        op2_sel_t op2_sel;
        reg_idx_t rs1;
        reg_idx_t rs2;
        reg_idx_t rd;
        logic     rd_we;
        word_t    imm;
        word_t    pc;
        logic     illegal;
    } dec_t;

    // Register/immediate ALU class from funct3; alt_sub/alt_sra come from insn[30].
    function automatic alu_op_t f3_to_alu(input logic [2:0] f3, input logic alt_sub,
                                          input logic alt_sra);
        alu_op_t op;
        op = ALU_ADD;
        case (f3)
            F3_ADD_SUB: op = alt_sub ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SRL_SRA: op = alt_sra ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            F3_AND:     op = ALU_AND;
            default:    op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_logic.sv
// Combinational RV32I decoder producing the execute-stage payload.
// Define ILLEGAL_INSN_EN to report unsupported encodings on the illegal flag.
module decode_logic
    import riscv_pkg::*;
(
    input  word_t insn_i,
    input  word_t pc_i,
    output dec_t  dec_o_c
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    word_t      imm_i;
    word_t      imm_s;
    word_t      imm_b;
    word_t      imm_u;
    word_t      imm_j;
    logic       bad;

    assign opcode = insn_i[6:0];
    assign f3     = insn_i[14:12];
    assign f7     = insn_i[31:25];

    assign imm_i = {{20{insn_i[31]}}, insn_i[31:20]};
    assign imm_s = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
    assign imm_b = {{19{insn_i[31]}}, insn_i[31], insn_i[7], insn_i[30:25], insn_i[11:8], 1'b0};
    assign imm_u = {insn_i[31:12], 12'b0};
    assign imm_j = {{11{insn_i[31]}}, insn_i[31], insn_i[19:12], insn_i[20], insn_i[30:21], 1'b0};

    // Any unsupported encoding still flows downstream as a harmless ADD without writeback.
    always_comb begin
        bad             = 1'b0;
        dec_o_c         = '0;
        dec_o_c.alu_op  = ALU_ADD;
        dec_o_c.op1_sel = OP1_RS1;
        dec_o_c.op2_sel = OP2_RS2;
        dec_o_c.rs1     = insn_i[19:15];
        dec_o_c.rs2     = insn_i[24:20];
        dec_o_c.rd      = insn_i[11:7];
        dec_o_c.pc      = pc_i;

        case (opcode)
            OPC_LUI: begin
                dec_o_c.alu_op  = ALU_OP2;
                dec_o_c.op1_sel = OP1_ZERO;
                dec_o_c.op2_sel = OP2_IMM;
                dec_o_c.imm     = imm_u;
                dec_o_c.rd_we   = 1'b1;
            end
            OPC_AUIPC: begin
                dec_o_c.op1_sel = OP1_PC;
                dec_o_c.op2_sel = OP2_IMM;
                dec_o_c.imm     = imm_u;
                dec_o_c.rd_we   = 1'b1;
            end
            OPC_JAL: begin
                dec_o_c.op1_sel = OP1_PC;
                dec_o_c.op2_sel = OP2_FOUR;
                dec_o_c.imm     = imm_j;
                dec_o_c.rd_we   = 1'b1;
            end
            OPC_JALR: begin
                dec_o_c.op1_sel = OP1_PC;
                dec_o_c.op2_sel = OP2_FOUR;
                dec_o_c.imm     = imm_i;
                dec_o_c.rd_we   = 1'b1;
                bad             = (f3 != F3_JALR);
            end
            OPC_BRANCH: begin
                dec_o_c.imm = imm_b;
                case (f3)
                    F3_BEQ, F3_BNE:   dec_o_c.alu_op = ALU_SUB;
                    F3_BLT, F3_BGE:   dec_o_c.alu_op = ALU_SLT;
                    F3_BLTU, F3_BGEU: dec_o_c.alu_op = ALU_SLTU;
                    default:          bad = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec_o_c.op2_sel = OP2_IMM;
                dec_o_c.imm     = imm_i;
                dec_o_c.rd_we   = 1'b1;
                case (f3)
                    F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: bad = 1'b0;
                    default:                             bad = 1'b1;
                endcase
            end
            OPC_STORE: begin
                dec_o_c.op2_sel = OP2_IMM;
                dec_o_c.imm     = imm_s;
                bad             = (f3 > F3_SW);
            end
            OPC_OP_IMM: begin
                dec_o_c.op2_sel = OP2_IMM;
                dec_o_c.imm     = imm_i;
                dec_o_c.rd_we   = 1'b1;
                dec_o_c.alu_op  = f3_to_alu(f3, 1'b0, insn_i[30]);
                if (f3 == F3_SLL) begin
                    bad = (f7 != F7_BASE);
                end else if (f3 == F3_SRL_SRA) begin
                    bad = (f7 != F7_BASE) && (f7 != F7_ALT);
                end
            end
            OPC_OP: begin
                dec_o_c.rd_we  = 1'b1;
                dec_o_c.alu_op = f3_to_alu(f3, insn_i[30], insn_i[30]);
                bad = !((f7 == F7_BASE) ||
                        ((f7 == F7_ALT) && ((f3 == F3_ADD_SUB) || (f3 == F3_SRL_SRA))));
            end
            default: bad = 1'b1;
        endcase

        if (insn_i[1:0] != 2'b11) begin
            bad = 1'b1;
        end
        if (bad) begin
            dec_o_c.alu_op = ALU_ADD;
            dec_o_c.rd_we  = 1'b0;
        end
        if (dec_o_c.rd == '0) begin
            dec_o_c.rd_we = 1'b0;
        end

`ifdef ILLEGAL_INSN_EN
        dec_o_c.illegal = bad;
`else
        dec_o_c.illegal = 1'b0;
`endif
    end

endmodule

// File: rtl/decode.sv
// Decode stage: fetch/execute handshakes around decode_logic with a registered output buffer.
// SKID=1 gives a two-entry FIFO with a flopped in_ready; ILLEGAL_INSN_EN enables illegal reporting.
module decode
    import riscv_pkg::*;
#(
    parameter int unsigned SKID = 1
) (
    input  logic     clk,
    input  logic     resetn,
    input  logic     flush,
    input  logic     in_valid,
    output logic     in_ready,
    input  word_t    in_insn,
    input  word_t    in_pc,
    output logic     out_valid,
    input  logic     out_ready,
    output alu_op_t  out_alu_op,
    output op1_sel_t out_op1_sel,
    output op2_sel_t out_op2_sel,
    output logic [4:0] out_rs1,
    output logic [4:0] out_rs2,
    output logic [4:0] out_rd,
    output logic     out_rd_we,
    output word_t    out_imm,
    output word_t    out_pc,
    output logic     out_illegal
);

    dec_t        dec_c;
    skid_state_t state_q, state_d;
    dec_t        head_q, head_d;
    dec_t        tail_q, tail_d;
    logic        valid_q, valid_d;
    logic        in_ready_q, in_ready_d;
    logic        accept;
    logic        drain;

    decode_logic u_logic (
        .insn_i  (in_insn),
        .pc_i    (in_pc),
        .dec_o_c (dec_c)
    );

    // in_ready_q stays low through reset and rises on the first edge after it.
    generate
        if (SKID != 0) begin : g_skid
            assign in_ready = in_ready_q;
        end else begin : g_single
            assign in_ready = in_ready_q && (!valid_q || out_ready);
        end
    endgenerate

    assign accept = in_valid && in_ready;
    assign drain  = valid_q && out_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_EMPTY;
            head_q     <= '0;
            tail_q     <= '0;
            valid_q    <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            valid_q    <= valid_d;
            in_ready_q <= in_ready_d;
        end
    end

    // head_q is always the oldest entry; tail_q only holds data in S_FULL.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;

        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    head_d  = dec_c;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (accept && drain) begin
                    head_d = dec_c;
                end else if (accept) begin
                    tail_d  = dec_c;
                    state_d = S_FULL;
                end else if (drain) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (drain) begin
                    head_d  = tail_q;
                    state_d = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase

        // Flush beats any same-cycle accept.
        if (flush) begin
            state_d = S_EMPTY;
        end

        valid_d    = (state_d != S_EMPTY);
        in_ready_d = (state_d != S_FULL);
    end

    assign out_valid   = valid_q;
    assign out_alu_op  = head_q.alu_op;
    assign out_op1_sel = head_q.op1_sel;
    assign out_op2_sel = head_q.op2_sel;
    assign out_rs1     = head_q.rs1;
    assign out_rs2     = head_q.rs2;
    assign out_rd      = head_q.rd;
    assign out_rd_we   = head_q.rd_we;
    assign out_imm     = head_q.imm;
    assign out_pc      = head_q.pc;
    assign out_illegal = head_q.illegal;

endmodule

// File: tb/tb_decode.sv
// Self-checking bench for decode: directed vectors, backpressure, flush, reset and a
// randomized stream checked against a spec-level model for both SKID=1 and SKID=0.
module tb_decode;
    import riscv_pkg::*;

    logic     clk = 1'b0;
    logic     resetn = 1'b0;
    logic     flush = 1'b0;
    logic     in_valid = 1'b0;
    logic     out_ready = 1'b0;
    word_t    in_insn = '0;
    word_t    in_pc = '0;

    logic     in_ready, out_valid, out_rd_we, out_illegal;
    alu_op_t  out_alu_op;
    op1_sel_t out_op1_sel;
    op2_sel_t out_op2_sel;
    logic [4:0] out_rs1, out_rs2, out_rd;
    word_t    out_imm, out_pc;

    logic     in_ready0, out_valid0, out_rd_we0, out_illegal0;
    alu_op_t  out_alu_op0;
    op1_sel_t out_op1_sel0;
    op2_sel_t out_op2_sel0;
    logic [4:0] out_rs10, out_rs20, out_rd0;
    word_t    out_imm0, out_pc0;

    int checks = 0;
    int failures = 0;

    decode #(.SKID(1)) u_dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_op(out_alu_op), .out_op1_sel(out_op1_sel), .out_op2_sel(out_op2_sel),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_rd_we(out_rd_we),
        .out_imm(out_imm), .out_pc(out_pc), .out_illegal(out_illegal)
    );

    decode #(.SKID(0)) u_dut0 (
        .clk(clk), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_insn(in_insn), .in_pc(in_pc),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_alu_op(out_alu_op0), .out_op1_sel(out_op1_sel0), .out_op2_sel(out_op2_sel0),
        .out_rs1(out_rs10), .out_rs2(out_rs20), .out_rd(out_rd0), .out_rd_we(out_rd_we0),
        .out_imm(out_imm0), .out_pc(out_pc0), .out_illegal(out_illegal0)
    );

    always #5 clk = ~clk;

    dec_t obs1, obs0;
    always_comb begin
        obs1.alu_op = out_alu_op;   obs1.op1_sel = out_op1_sel; obs1.op2_sel = out_op2_sel;
        obs1.rs1 = out_rs1;         obs1.rs2 = out_rs2;         obs1.rd = out_rd;
        obs1.rd_we = out_rd_we;     obs1.imm = out_imm;         obs1.pc = out_pc;
        obs1.illegal = out_illegal;
        obs0.alu_op = out_alu_op0;  obs0.op1_sel = out_op1_sel0; obs0.op2_sel = out_op2_sel0;
        obs0.rs1 = out_rs10;        obs0.rs2 = out_rs20;        obs0.rd = out_rd0;
        obs0.rd_we = out_rd_we0;    obs0.imm = out_imm0;        obs0.pc = out_pc0;
        obs0.illegal = out_illegal0;
    end

    // Reference decode written from the RV32I field rules with plain arithmetic and tables.
    function automatic dec_t model(input word_t insn, input word_t pc);
        dec_t m;
        logic bad;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic signed [12:0] b13;
        logic signed [20:0] j21;
        word_t ii;
        alu_op_t f3tab [0:7] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        alu_op_t brtab [0:7] = '{ALU_SUB, ALU_SUB, ALU_ADD, ALU_ADD, ALU_SLT, ALU_SLT, ALU_SLTU, ALU_SLTU};
        opc = insn[6:0];
        f3  = insn[14:12];
        f7  = insn[31:25];
        ii  = word_t'($signed(insn) >>> 20);
        b13 = {insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
        j21 = {insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
        m = '0;
        m.rs1 = insn[19:15]; m.rs2 = insn[24:20]; m.rd = insn[11:7]; m.pc = pc;
        m.alu_op = ALU_ADD; m.op1_sel = OP1_RS1; m.op2_sel = OP2_RS2;
        bad = 1'b0;
        case (opc)
            7'h37: begin m.alu_op = ALU_OP2; m.op1_sel = OP1_ZERO; m.op2_sel = OP2_IMM;
                         m.imm = insn & 32'hFFFF_F000; m.rd_we = 1'b1; end
            7'h17: begin m.op1_sel = OP1_PC; m.op2_sel = OP2_IMM;
                         m.imm = insn & 32'hFFFF_F000; m.rd_we = 1'b1; end
            7'h6F: begin m.op1_sel = OP1_PC; m.op2_sel = OP2_FOUR;
                         m.imm = word_t'(int'(j21)); m.rd_we = 1'b1; end
            7'h67: begin m.op1_sel = OP1_PC; m.op2_sel = OP2_FOUR; m.imm = ii; m.rd_we = 1'b1;
                         bad = (f3 != 3'd0); end
            7'h63: begin m.imm = word_t'(int'(b13)); m.alu_op = brtab[f3];
                         bad = (f3 == 3'd2) || (f3 == 3'd3); end
            7'h03: begin m.op2_sel = OP2_IMM; m.imm = ii; m.rd_we = 1'b1;
                         bad = (f3 == 3'd3) || (f3 > 3'd5); end
            7'h23: begin m.op2_sel = OP2_IMM; m.imm = {ii[31:5], insn[11:7]}; bad = (f3 > 3'd2); end
            7'h13: begin
                m.op2_sel = OP2_IMM; m.imm = ii; m.rd_we = 1'b1; m.alu_op = f3tab[f3];
                if (f3 == 3'd5 && insn[30]) m.alu_op = ALU_SRA;
                bad = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
            end
            7'h33: begin
                m.rd_we = 1'b1; m.alu_op = f3tab[f3];
                if (f3 == 3'd0 && insn[30]) m.alu_op = ALU_SUB;
                if (f3 == 3'd5 && insn[30]) m.alu_op = ALU_SRA;
                bad = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            end
            default: bad = 1'b1;
        endcase
        if (insn[1:0] != 2'b11) bad = 1'b1;
        if (bad) begin m.alu_op = ALU_ADD; m.rd_we = 1'b0; end
`ifdef ILLEGAL_INSN_EN
        m.illegal = bad;
`endif
        if (m.rd == 5'd0) m.rd_we = 1'b0;
        return m;
    endfunction

    function automatic word_t rand_insn();
        logic [6:0] ops [0:9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F};
        word_t w = $urandom;
        int k = $urandom_range(0, 11);
        if (k < 10) w[6:0] = ops[k];
        if ($urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        return w;
    endfunction

    task automatic test_reset();
        resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        checks++; if (in_ready0 !== 1'b0) begin failures++; $display("FAIL rst_in_ready0 got=%b exp=0", in_ready0); end
        checks++; if (obs1 !== dec_t'('0)) begin failures++; $display("FAIL rst_outputs got=%h exp=0", obs1); end
        resetn = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_ready_early got=%b exp=0", in_ready); end
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_rise got=%b exp=1", in_ready); end
        checks++; if (in_ready0 !== 1'b1) begin failures++; $display("FAIL rst_ready_rise0 got=%b exp=1", in_ready0); end
    endtask

    task automatic test_vectors();
        word_t vi [0:3] = '{32'hFFF1_0093, 32'h4020_81B3, 32'h1234_52B7, 32'h0000_0000};
        logic exp_ill;
`ifdef ILLEGAL_INSN_EN
        exp_ill = 1'b1;
`else
        exp_ill = 1'b0;
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_insn = vi[i]; in_pc = 32'h1000 + 32'(4 * i);
            #1;
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL vec_ready i=%0d got=%b exp=1", i, in_ready); end
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if ({out_valid, out_pc} !== {1'b1, 32'h1000 + 32'(4 * i)}) begin
                failures++; $display("FAIL vec_latency i=%0d got=%b/%h exp=1/%h", i, out_valid, out_pc, 32'h1000 + 32'(4 * i));
            end
            checks++;
            case (i)
                0: if ({out_alu_op, out_op1_sel, out_op2_sel, out_rs1, out_rd, out_rd_we, out_imm} !==
                       {ALU_ADD, OP1_RS1, OP2_IMM, 5'd2, 5'd1, 1'b1, 32'hFFFF_FFFF}) begin
                       failures++; $display("FAIL vec_addi got=%h", obs1); end
                1: if ({out_alu_op, out_op1_sel, out_op2_sel, out_rs1, out_rs2, out_rd, out_rd_we} !==
                       {ALU_SUB, OP1_RS1, OP2_RS2, 5'd1, 5'd2, 5'd3, 1'b1}) begin
                       failures++; $display("FAIL vec_sub got=%h", obs1); end
                2: if ({out_alu_op, out_op1_sel, out_op2_sel, out_imm, out_rd, out_rd_we} !==
                       {ALU_OP2, OP1_ZERO, OP2_IMM, 32'h1234_5000, 5'd5, 1'b1}) begin
                       failures++; $display("FAIL vec_lui got=%h", obs1); end
                default: if ({out_illegal, out_rd_we, out_alu_op} !== {exp_ill, 1'b0, ALU_ADD}) begin
                       failures++; $display("FAIL vec_zero got=%b/%b/%0d exp=%b/0/0", out_illegal, out_rd_we, out_alu_op, exp_ill); end
            endcase
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        dec_t exp [0:2];
        int nacc = 2;
        int ndr = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            in_valid = 1'b1; in_insn = rand_insn(); in_pc = 32'hA000 + 32'(4 * k);
            exp[k] = model(in_insn, in_pc);
            if (k == 1) begin
                checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready1 got=%b exp=1", in_ready); end
            end
            if (k == 2) begin
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_fall got=%b exp=0", in_ready); end
            end
        end
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, obs1} !== {1'b0, 1'b1, exp[0]}) begin
            failures++; $display("FAIL bp_hold got=%b/%b/%h exp=0/1/%h", in_ready, out_valid, obs1, exp[0]);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (ndr > 2) begin failures++; $display("FAIL bp_dup got=%h", obs1); end
                else if (obs1 !== exp[ndr]) begin failures++; $display("FAIL bp_order n=%0d got=%h exp=%h", ndr, obs1, exp[ndr]); end
                ndr++;
            end
            if (in_valid && in_ready) nacc++;
            @(negedge clk);
            if (nacc == 3) in_valid = 1'b0;
        end
        checks++; if (ndr != 3) begin failures++; $display("FAIL bp_count got=%0d exp=3", ndr); end
    endtask

    task automatic test_flush();
        int seen = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_insn = rand_insn(); in_pc = 32'hB000 + 32'(4 * k);
        end
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fl_full got=%b exp=0", in_ready); end
        flush = 1'b1; in_insn = 32'h0010_0093; in_pc = 32'hDEAD_0000;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fl_valid got=%b exp=0", out_valid); end
        out_ready = 1'b1;
        repeat (3) begin @(negedge clk); if (out_valid !== 1'b0) seen++; end
        checks++; if (seen != 0) begin failures++; $display("FAIL fl_leak got=%0d exp=0", seen); end
        in_valid = 1'b1; flush = 1'b1; in_insn = 32'h0020_0113; in_pc = 32'hE000;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fl_acc_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fl_accept got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            in_valid = 1'b1; in_insn = rand_insn(); in_pc = 32'hC000 + 32'(4 * k);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rm_pre got=%b exp=1", out_valid); end
        resetn = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b00) begin failures++; $display("FAIL rm_async got=%b%b exp=00", out_valid, in_ready); end
        @(negedge clk);
        resetn = 1'b1; out_ready = 1'b1;
        repeat (4) begin @(negedge clk); if (out_valid !== 1'b0) seen++; end
        checks++; if (seen != 0) begin failures++; $display("FAIL rm_leak got=%0d exp=0", seen); end
    endtask

    task automatic test_random();
        dec_t q1 [$];
        dec_t q0 [$];
        int pct [0:2] = '{20, 55, 90};
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== (q1.size() != 0)) begin failures++; $display("FAIL rnd_valid1 c=%0d got=%b exp=%0d", cyc, out_valid, q1.size()); end
            else if (q1.size() != 0 && obs1 !== q1[0]) begin failures++; $display("FAIL rnd_data1 c=%0d got=%h exp=%h", cyc, obs1, q1[0]); end
            checks++;
            if (in_ready !== (q1.size() < 2)) begin failures++; $display("FAIL rnd_ready1 c=%0d got=%b size=%0d", cyc, in_ready, q1.size()); end
            checks++;
            if (out_valid0 !== (q0.size() != 0)) begin failures++; $display("FAIL rnd_valid0 c=%0d got=%b exp=%0d", cyc, out_valid0, q0.size()); end
            else if (q0.size() != 0 && obs0 !== q0[0]) begin failures++; $display("FAIL rnd_data0 c=%0d got=%h exp=%h", cyc, obs0, q0[0]); end
            in_valid  = ($urandom_range(0, 3) != 0);
            in_insn   = rand_insn();
            in_pc     = $urandom;
            out_ready = ($urandom_range(0, 99) < pct[(cyc / 250) % 3]);
            flush     = ($urandom_range(0, 39) == 0);
            #1;
            checks++;
            if (in_ready0 !== ((q0.size() == 0) || out_ready)) begin
                failures++; $display("FAIL rnd_ready0 c=%0d got=%b size=%0d rdy=%b", cyc, in_ready0, q0.size(), out_ready);
            end
            if (flush) begin
                q1.delete(); q0.delete();
            end else begin
                if (out_valid && out_ready && q1.size() != 0) void'(q1.pop_front());
                if (in_valid && in_ready) q1.push_back(model(in_insn, in_pc));
                if (out_valid0 && out_ready && q0.size() != 0) void'(q0.pop_front());
                if (in_valid && in_ready0) q0.push_back(model(in_insn, in_pc));
            end
        end
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/decode.md
DECODE -- requirements
Module: decode

Interface
REQ-001 Parameter SKID, default 1: 1 = two-entry skid output buffer with registered in_ready; 0 = single output register.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 flush  input  1  discard all buffered decodes this cycle.
REQ-005 in_valid/in_ready  input/output  1/1  fetch handshake.
REQ-006 in_insn, in_pc  input  word_t each  instruction word and its address.
REQ-007 out_valid/out_ready  output/input  1/1  execute-side handshake.
REQ-008 out_alu_op  output  alu_op_t  ALU operation for execute stage.
REQ-009 out_op1_sel  output  op1_sel_t  RS1, PC or ZERO.
REQ-010 out_op2_sel  output  op2_sel_t  RS2, IMM or FOUR.
REQ-011 out_rs1, out_rs2, out_rd  output  5 each  register indices.
REQ-012 out_rd_we  output  1  destination write enable, forced 0 when rd = 0.
REQ-013 out_imm, out_pc  output  word_t each  sign-extended immediate; passed-through PC.
REQ-014 out_illegal  output  1  instruction not in RV32I base set.

Function
REQ-015 Transfer on either side SHALL occur only when valid and ready are both high at a rising clk edge.
REQ-016 Latency SHALL be 1 cycle: an accepted instruction SHALL appear on out_* in the next cycle.
REQ-017 The decode SHALL be combinational on in_insn; all out_* SHALL be registered.
REQ-018 out_* SHALL be held stable while out_valid is high and out_ready is low.
REQ-019 SKID=0: in_ready SHALL equal !out_valid || out_ready.
REQ-020 SKID=1: in_ready SHALL be a flop, high iff fewer than 2 entries are held; order SHALL be FIFO; states EMPTY, ONE, FULL.
REQ-021 SKID=1 transitions: accept-only increments; drain-only decrements; accept and drain in the same cycle holds state.
REQ-022 flush SHALL drop all entries, deassert out_valid next cycle, and win over a simultaneous accept (that instruction is discarded).
REQ-023 Mapping: LUI gives OP2/ZERO/IMM; AUIPC gives ADD/PC/IMM; JAL and JALR give ADD/PC/FOUR.
REQ-024 Mapping: loads and stores SHALL give ADD/RS1/IMM; stores and branches SHALL force rd_we = 0.
REQ-025 Mapping: BEQ/BNE SHALL give SUB; BLT/BGE SHALL give SLT; BLTU/BGEU SHALL give SLTU.
REQ-026 OP-IMM/OP funct3 SHALL select ADD, SLL, SLT, SLTU, XOR, SRL, OR or AND; insn[30] SHALL select SUB (OP only) or SRA.
REQ-027 Immediates SHALL be I/S/B/U/J formatted with sign from insn[31]; U-type low 12 bits SHALL be zero.
REQ-028 An illegal instruction SHALL still be passed downstream with out_rd_we = 0 and out_alu_op = ALU_ADD.

Reset
REQ-029 While resetn is low: out_valid = 0; in_ready = 0; skid state = EMPTY; all other out_* = 0.
REQ-030 in_ready SHALL rise on the first clk edge after resetn deasserts.
REQ-031 Reset mid-transfer SHALL discard all held entries without emitting them.

Configuration
REQ-032 With ILLEGAL_INSN_EN defined, out_illegal SHALL be set for:
  - insn[1:0] != 2'b11;
  - an unknown opcode;
  - a bad funct7 on OP or on a shift-immediate;
  - a bad funct3 on load, store, branch or JALR.
REQ-033 Without ILLEGAL_INSN_EN, out_illegal SHALL be tied to 0 and unknown encodings SHALL decode as ADD with rd_we = 0.

Structure
REQ-034 op1_sel_t, op2_sel_t, opcode constants and the RV32I funct3/funct7 constants SHALL live in the shared riscv package, alongside word_t and alu_op_t.
REQ-035 The combinational decoder SHALL be a sub-module, decode_logic; the handshake and buffering logic SHALL stay in decode.

Verification
REQ-036 Input 0xFFF10093 (addi x1,x2,-1) -> ADD, RS1, IMM, rs1 = 2, rd = 1, rd_we = 1, imm = 0xFFFFFFFF.
REQ-037 Input 0x402081B3 (sub x3,x1,x2) -> SUB, RS1, RS2, rs1 = 1, rs2 = 2, rd = 3.
REQ-038 Input 0x123452B7 (lui x5) -> OP2, imm = 0x12345000, rd = 5.
REQ-039 SKID=1, out_ready low for 3 cycles while 3 instructions are offered:
  - in_ready falls after the 2nd accept;
  - on release, outputs emerge in order with no loss or duplication.
REQ-040 Input 0x00000000 -> out_illegal = 1 and rd_we = 0 with ILLEGAL_INSN_EN; out_illegal = 0 without it.
REQ-041 flush asserted together with in_valid while FULL -> out_valid = 0 next cycle; the flushed instruction never appears.
